// File: rtl/calc_sequencer.sv
// Operand-entry / calculation sequencer: collects NUM_OPERANDS writes, then CALC and DONE.
// Optional macro CALC_SEQ_NEXT_SYNC_EN adds a two-flop synchroniser on `next`.
module calc_sequencer #(
  parameter int NUM_OPERANDS = 2,
  parameter int ADDR_W       = 2,
  parameter int MODE_W       = 3,
  parameter int MS_OUT_W     = 4
) (
  input  logic                CLK,
  input  logic                clear,
  input  logic                next,
  input  logic [MODE_W-1:0]   MS,
  output logic [MS_OUT_W-1:0] MS_out,
  output logic                WE,
  output logic [ADDR_W-1:0]   W_addr,
  output logic [1:0]          LEDsel,
  output logic                Done_out
);

  typedef enum logic [2:0] {
    IDLE_IN = 3'b000,
    LOAD    = 3'b001,
    CALC    = 3'b010,
    DONE    = 3'b100
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OPERANDS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic                next_prev_q;
  logic                next_s;
  logic                press;

`ifdef CALC_SEQ_NEXT_SYNC_EN
  logic sync1_q, sync2_q;

  // Synchroniser resets high so a button held through clear looks like "already pressed".
  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= next;
      sync2_q <= sync1_q;
    end
  end

  assign next_s = sync2_q;
`else
  assign next_s = next;
`endif

  assign press = next_s & ~next_prev_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE_IN: if (press) state_d = LOAD;
      LOAD: begin
        if (idx_q == LAST_IDX) begin
          state_d = CALC;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = IDLE_IN;
        end
      end
      CALC: begin
        if (press) begin
          mode_d  = MS;
          state_d = DONE;
        end
      end
      DONE: begin
        if (press) begin
          idx_d   = '0;
          state_d = IDLE_IN;
        end
      end
      default: begin
        state_d = IDLE_IN;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      state_q     <= IDLE_IN;
      idx_q       <= '0;
      mode_q      <= '0;
      next_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      next_prev_q <= next_s;
    end
  end

  // Moore decode straight from the state register so clear removes WE without waiting for a clock.
  always_comb begin
    WE       = 1'b0;
    W_addr   = idx_q;
    LEDsel   = 2'b00;
    MS_out   = '0;
    Done_out = 1'b0;
    case (state_q)
      IDLE_IN: ;
      LOAD:    WE = 1'b1;
      CALC: begin
        LEDsel = 2'b01;
        MS_out = MS_OUT_W'(MS);
      end
      DONE: begin
        LEDsel   = 2'b10;
        MS_out   = MS_OUT_W'(mode_q);
        Done_out = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with NUM_OPERANDS=3.
module tb_calc_sequencer;

`ifdef CALC_SEQ_NEXT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       CLK = 1'b0;
  logic       clear;
  logic       next;
  logic [2:0] MS;
  logic [3:0] MS_out;
  logic       WE;
  logic [1:0] W_addr;
  logic [1:0] LEDsel;
  logic       Done_out;

  int checks = 0;
  int errors = 0;
  int we_count;

  calc_sequencer #(
    .NUM_OPERANDS(3),
    .ADDR_W(2),
    .MODE_W(3),
    .MS_OUT_W(4)
  ) dut (
    .CLK(CLK),
    .clear(clear),
    .next(next),
    .MS(MS),
    .MS_out(MS_out),
    .WE(WE),
    .W_addr(W_addr),
    .LEDsel(LEDsel),
    .Done_out(Done_out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Release next long enough to clear the edge detector, then raise it and wait for the reaction.
  task automatic raise_next();
    @(negedge CLK) next = 1'b0;
    repeat (LAT + 1) @(negedge CLK);
    next = 1'b1;
    repeat (LAT - 1) begin
      @(posedge CLK); #1;
      check("we_before_latency", 32'(WE), 32'd0);
    end
    @(posedge CLK); #1;
  endtask

  task automatic press_write(input logic [1:0] addr, input string tag);
    raise_next();
    check({tag, "_we"}, 32'(WE), 32'd1);
    check({tag, "_addr"}, 32'(W_addr), 32'(addr));
    @(negedge CLK) next = 1'b0;
    @(posedge CLK); #1;
    check({tag, "_we_single"}, 32'(WE), 32'd0);
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    clear = 1'b1;
    next  = 1'b1;
    MS    = 3'b000;
    #1;
    check("rst_we", 32'(WE), 32'd0);
    check("rst_addr", 32'(W_addr), 32'd0);
    check("rst_led", 32'(LEDsel), 32'd0);
    check("rst_ms", 32'(MS_out), 32'd0);
    check("rst_done", 32'(Done_out), 32'd0);
    repeat (3) @(negedge CLK);
    clear = 1'b0;

    // next held through and after reset: nothing fires
    we_count = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (WE) we_count++;
    end
    check("held_reset_we", 32'(we_count), 32'd0);
    check("held_reset_led", 32'(LEDsel), 32'd0);
    check("held_reset_done", 32'(Done_out), 32'd0);

    press_write(2'd0, "op0");
    check("op0_idle_led", 32'(LEDsel), 32'd0);
    press_write(2'd1, "op1");
    press_write(2'd2, "op2");
    check("calc_led", 32'(LEDsel), 32'd1);
    check("calc_done", 32'(Done_out), 32'd0);
    check("calc_ms_live0", 32'(MS_out), 32'd0);
    MS = 3'b101;
    #1;
    check("calc_ms_live5", 32'(MS_out), 32'h5);

    raise_next();
    check("done_flag", 32'(Done_out), 32'd1);
    check("done_led", 32'(LEDsel), 32'd2);
    check("done_ms", 32'(MS_out), 32'h5);
    check("done_we", 32'(WE), 32'd0);
    MS = 3'b010;
    @(posedge CLK); #1;
    check("done_ms_frozen", 32'(MS_out), 32'h5);

    raise_next();
    check("restart_done", 32'(Done_out), 32'd0);
    check("restart_led", 32'(LEDsel), 32'd0);
    check("restart_addr", 32'(W_addr), 32'd0);
    check("restart_we", 32'(WE), 32'd0);
    press_write(2'd0, "restart_op0");

    // Held button for 20 cycles produces a single write (idx 1)
    @(negedge CLK) next = 1'b0;
    repeat (LAT + 1) @(negedge CLK);
    next = 1'b1;
    we_count = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (WE) begin
        we_count++;
        check("held_addr", 32'(W_addr), 32'd1);
      end
    end
    check("held_we_count", 32'(we_count), 32'd1);

    // clear while in LOAD of idx 2
    raise_next();
    check("abort_we_pre", 32'(WE), 32'd1);
    check("abort_addr_pre", 32'(W_addr), 32'd2);
    #1 clear = 1'b1;
    #1;
    check("abort_we", 32'(WE), 32'd0);
    check("abort_addr", 32'(W_addr), 32'd0);
    check("abort_led", 32'(LEDsel), 32'd0);
    @(negedge CLK) clear = 1'b0;
    repeat (2) @(negedge CLK);
    check("abort_idle_we", 32'(WE), 32'd0);
    press_write(2'd0, "post_clear");
    check("post_clear_addr_next", 32'(W_addr), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
